// File: rtl/mem_stage_ctrl.sv
// MEM-stage controller: turns EX/MEM load/store requests into a req/ready memory handshake,
// stalls upstream during the access and presents write-back fields to MEM/WB.
module mem_stage_ctrl #(
    parameter int unsigned n           = 32,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic         clk,
    input  logic         reset_in,
    input  logic         RegWrite_in,
    input  logic         MemtoReg_in,
    input  logic         MemRead_in,
    input  logic         MemWrite_in,
    input  logic [n-1:0] ALU_Result_in,
    input  logic [n-1:0] RT_data_in,
    input  logic [4:0]   Rd_in,
    output logic         mem_req,
    output logic         mem_we,
    output logic [n-1:0] mem_addr,
    output logic [n-1:0] mem_wdata,
    input  logic         mem_ready,
    input  logic [n-1:0] mem_rdata,
    output logic         stall_out,
    output logic         RegWrite_out,
    output logic         MemtoReg_out,
    output logic [n-1:0] Read_data_out,
    output logic [n-1:0] ALU_Result_out,
    output logic [4:0]   Rd_out,
    output logic         misalign_out,
    output logic         bus_err_out
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

    state_e         state_q, state_d;
    logic           req_q, we_q;
    logic [n-1:0]   addr_q, wdata_q, alu_q, rdata_q;
    logic [4:0]     rd_q;
    logic           regwrite_q, memtoreg_q, err_q;
    logic [CntW-1:0] cnt_q;

    logic access, aligned, start, ready_hit, timeout_hit;

    assign access      = MemRead_in | MemWrite_in;
    assign aligned     = (ALU_Result_in[1:0] == 2'b00);
    assign start       = (state_q == StIdle) && access && aligned;
    assign ready_hit   = (state_q == StReq) && req_q && mem_ready;
    // Ready on the limit cycle takes priority over the timeout abort.
    assign timeout_hit = (state_q == StReq) && !mem_ready && (cnt_q == CntW'(TIMEOUT_CYC - 1));

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_ff @(posedge clk) begin
        if (reset_in) state_q <= StIdle;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StReq;
            StReq:   if (ready_hit || timeout_hit) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_in) begin
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            alu_q      <= '0;
            rdata_q    <= '0;
            rd_q       <= '0;
            regwrite_q <= 1'b0;
            memtoreg_q <= 1'b0;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else if (start) begin
            req_q      <= 1'b1;
            we_q       <= MemWrite_in;
            addr_q     <= {ALU_Result_in[n-1:2], 2'b00};
            wdata_q    <= RT_data_in;
            alu_q      <= ALU_Result_in;
            rdata_q    <= '0;
            rd_q       <= Rd_in;
            regwrite_q <= RegWrite_in;
            memtoreg_q <= MemtoReg_in;
            err_q      <= 1'b0;
            cnt_q      <= '0;
        end else if (ready_hit) begin
            req_q   <= 1'b0;
            rdata_q <= we_q ? '0 : mem_rdata;
        end else if (timeout_hit) begin
            req_q <= 1'b0;
            err_q <= 1'b1;
        end else if (state_q == StReq) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_comb begin
        stall_out      = 1'b0;
        RegWrite_out   = 1'b0;
        MemtoReg_out   = 1'b0;
        Read_data_out  = '0;
        ALU_Result_out = '0;
        Rd_out         = '0;
        misalign_out   = 1'b0;
        bus_err_out    = 1'b0;
        if (!reset_in) begin
            unique case (state_q)
                StIdle: begin
                    RegWrite_out   = RegWrite_in;
                    MemtoReg_out   = MemtoReg_in;
                    ALU_Result_out = ALU_Result_in;
                    Rd_out         = Rd_in;
                    // A memory op holds write-back until its DONE cycle.
                    if (access) begin
                        RegWrite_out = 1'b0;
                        if (aligned) stall_out = 1'b1;
                        else         misalign_out = 1'b1;
                    end
                end
                StReq: begin
                    stall_out      = 1'b1;
                    MemtoReg_out   = memtoreg_q;
                    ALU_Result_out = alu_q;
                    Rd_out         = rd_q;
                end
                StDone: begin
                    RegWrite_out   = regwrite_q & ~err_q;
                    MemtoReg_out   = memtoreg_q;
                    Read_data_out  = rdata_q;
                    ALU_Result_out = alu_q;
                    Rd_out         = rd_q;
                    bus_err_out    = err_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Directed bench for mem_stage_ctrl: pass-through, load/store handshakes, misalignment,
// timeout abort, ready-at-limit and reset during an access.
module tb_mem_stage_ctrl;

    logic        clk = 1'b0;
    logic        reset_in;
    logic        RegWrite_in, MemtoReg_in, MemRead_in, MemWrite_in;
    logic [31:0] ALU_Result_in, RT_data_in;
    logic [4:0]  Rd_in;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        stall_out, RegWrite_out, MemtoReg_out;
    logic [31:0] Read_data_out, ALU_Result_out;
    logic [4:0]  Rd_out;
    logic        misalign_out, bus_err_out;

    int checks = 0;
    int errors = 0;
    int req_cycles;

    mem_stage_ctrl #(.n(32), .TIMEOUT_CYC(64)) dut (
        .clk            (clk),
        .reset_in       (reset_in),
        .RegWrite_in    (RegWrite_in),
        .MemtoReg_in    (MemtoReg_in),
        .MemRead_in     (MemRead_in),
        .MemWrite_in    (MemWrite_in),
        .ALU_Result_in  (ALU_Result_in),
        .RT_data_in     (RT_data_in),
        .Rd_in          (Rd_in),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata),
        .stall_out      (stall_out),
        .RegWrite_out   (RegWrite_out),
        .MemtoReg_out   (MemtoReg_out),
        .Read_data_out  (Read_data_out),
        .ALU_Result_out (ALU_Result_out),
        .Rd_out         (Rd_out),
        .misalign_out   (misalign_out),
        .bus_err_out    (bus_err_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic rw, input logic mtr, input logic mr, input logic mw,
                          input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] rd);
        RegWrite_in   = rw;
        MemtoReg_in   = mtr;
        MemRead_in    = mr;
        MemWrite_in   = mw;
        ALU_Result_in = alu;
        RT_data_in    = rt;
        Rd_in         = rd;
        #1;
    endtask

    initial begin
        reset_in  = 1'b1;
        mem_ready = 1'b0;
        mem_rdata = '0;
        set_in(1, 1, 0, 0, 32'h55, 32'h66, 5'd3);
        tick();
        tick();
        check("rst_stall", stall_out, 0);
        check("rst_regwrite", RegWrite_out, 0);
        check("rst_alu", ALU_Result_out, 0);
        check("rst_rd", Rd_out, 0);
        check("rst_req", mem_req, 0);

        // Plain ALU op passes through combinationally
        reset_in = 1'b0;
        set_in(1, 0, 0, 0, 32'h1234, 0, 5'd5);
        check("alu_regwrite", RegWrite_out, 1);
        check("alu_rd", Rd_out, 5);
        check("alu_result", ALU_Result_out, 32'h1234);
        check("alu_stall", stall_out, 0);
        check("alu_req", mem_req, 0);
        check("alu_rdata", Read_data_out, 0);

        // Stray ready with no request is ignored
        mem_ready = 1'b1;
        tick();
        check("stray_ready_req", mem_req, 0);
        check("stray_ready_stall", stall_out, 0);
        mem_ready = 1'b0;

        // Load 0x100, ready on second REQ cycle -> three stall cycles
        set_in(1, 1, 1, 0, 32'h100, 0, 5'd7);
        check("ld_stall0", stall_out, 1);
        check("ld_req0", mem_req, 0);
        tick();
        check("ld_stall1", stall_out, 1);
        check("ld_req1", mem_req, 1);
        check("ld_we", mem_we, 0);
        check("ld_addr", mem_addr, 32'h100);
        tick();
        check("ld_stall2", stall_out, 1);
        check("ld_req2", mem_req, 1);
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ready = 1'b0;
        mem_rdata = '0;
        check("ld_done_stall", stall_out, 0);
        check("ld_done_req", mem_req, 0);
        check("ld_done_data", Read_data_out, 32'hDEADBEEF);
        check("ld_done_mtr", MemtoReg_out, 1);
        check("ld_done_rw", RegWrite_out, 1);
        check("ld_done_rd", Rd_out, 7);
        check("ld_done_alu", ALU_Result_out, 32'h100);
        check("ld_done_err", bus_err_out, 0);
        set_in(0, 0, 0, 0, 0, 0, 0);
        tick();
        check("ld_idle_stall", stall_out, 0);
        check("ld_idle_req", mem_req, 0);

        // Store 0x40, ready on first REQ cycle -> two stall cycles
        set_in(0, 0, 0, 1, 32'h40, 32'hA5A5A5A5, 5'd0);
        check("st_stall0", stall_out, 1);
        tick();
        check("st_stall1", stall_out, 1);
        check("st_req", mem_req, 1);
        check("st_we", mem_we, 1);
        check("st_addr", mem_addr, 32'h40);
        check("st_wdata", mem_wdata, 32'hA5A5A5A5);
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFF0000;
        tick();
        mem_ready = 1'b0;
        check("st_done_stall", stall_out, 0);
        check("st_done_rw", RegWrite_out, 0);
        check("st_done_rdata", Read_data_out, 0);
        check("st_done_req", mem_req, 0);
        set_in(0, 0, 0, 0, 0, 0, 0);
        tick();

        // Misaligned load: no request, one-cycle flag
        set_in(1, 1, 1, 0, 32'h102, 0, 5'd9);
        check("mis_flag", misalign_out, 1);
        check("mis_rw", RegWrite_out, 0);
        check("mis_stall", stall_out, 0);
        tick();
        check("mis_req", mem_req, 0);
        set_in(0, 0, 0, 0, 0, 0, 0);
        check("mis_flag_clear", misalign_out, 0);

        // Timeout: mem_ready never arrives
        set_in(1, 1, 1, 0, 32'h200, 0, 5'd11);
        tick();
        req_cycles = 0;
        while (mem_req && req_cycles < 200) begin
            req_cycles++;
            tick();
        end
        check("to_req_cycles", req_cycles, 64);
        check("to_err", bus_err_out, 1);
        check("to_rw", RegWrite_out, 0);
        check("to_stall", stall_out, 0);
        set_in(1, 1, 1, 0, 32'h300, 0, 5'd12);
        tick();
        check("to_next_err", bus_err_out, 0);
        check("to_next_stall", stall_out, 1);
        tick();
        check("to_next_req", mem_req, 1);
        check("to_next_addr", mem_addr, 32'h300);
        mem_ready = 1'b1;
        mem_rdata = 32'h12345678;
        tick();
        mem_ready = 1'b0;
        check("to_next_data", Read_data_out, 32'h12345678);
        check("to_next_rw", RegWrite_out, 1);
        check("to_next_done_err", bus_err_out, 0);
        set_in(0, 0, 0, 0, 0, 0, 0);
        tick();

        // Ready on the limit cycle completes normally
        set_in(1, 1, 1, 0, 32'h500, 0, 5'd13);
        tick();
        for (int i = 0; i < 63; i++) tick();
        check("lim_req_still", mem_req, 1);
        mem_ready = 1'b1;
        mem_rdata = 32'hCAFEF00D;
        tick();
        mem_ready = 1'b0;
        check("lim_err", bus_err_out, 0);
        check("lim_data", Read_data_out, 32'hCAFEF00D);
        check("lim_rw", RegWrite_out, 1);
        set_in(0, 0, 0, 0, 0, 0, 0);
        tick();

        // Reset during REQ drops the access
        set_in(1, 1, 1, 0, 32'h400, 0, 5'd14);
        tick();
        check("rr_req", mem_req, 1);
        reset_in = 1'b1;
        #1;
        check("rr_stall_in_rst", stall_out, 0);
        check("rr_rw_in_rst", RegWrite_out, 0);
        tick();
        reset_in = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0);
        check("rr_req_after", mem_req, 0);
        check("rr_stall_after", stall_out, 0);
        mem_ready = 1'b1;
        mem_rdata = 32'h77777777;
        tick();
        mem_ready = 1'b0;
        check("rr_late_req", mem_req, 0);
        check("rr_late_data", Read_data_out, 0);
        check("rr_late_stall", stall_out, 0);
        check("rr_late_err", bus_err_out, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
